// File: rtl/fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_queue_pkg
// Brief   : Shared types for the fetch queue (buffered entry layout).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package fetch_queue_pkg;

  localparam int FQ_ADDR_WIDTH = `ADDR_WIDTH;

  typedef struct packed {
    logic [31:0]              instr;
    logic [FQ_ADDR_WIDTH-1:0] pc;
    logic                     guesses_branch;
    logic [FQ_ADDR_WIDTH-1:0] prediction;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_ring.sv
//------------------------------------------------------------------------------
// Module  : fq_ring
// Brief   : DEPTH-entry circular buffer with head/tail/count, push/pop/clear.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fq_ring
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  fq_entry_t              i_push_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output fq_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        mem_d [DEPTH];

  // Clear wins over push/pop; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (i_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (i_push) begin
        mem_d[tail_q] = i_push_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (i_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign o_head  = mem_q[head_q];
  assign o_count = count_q;

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && !i_clear && (count_q == (PTR_W+1)'(DEPTH))));
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module  : fetch_queue
// Brief   : Fetch-PC generator and instruction buffer feeding the decoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    DEPTH      = 8,
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_fetch_req,
  output logic [ADDR_WIDTH-1:0] o_fetch_pc,
  input  logic                  i_fetch_ack,
  input  logic                  i_rsp_valid,
  input  logic [31:0]           i_rsp_instr,
  input  logic [ADDR_WIDTH-1:0] i_rsp_pc,
  input  logic                  i_rsp_guesses_branch,
  input  logic [ADDR_WIDTH-1:0] i_rsp_prediction,
  output logic                  o_dec_valid,
  output logic [31:0]           o_dec_instr,
  output logic [ADDR_WIDTH-1:0] o_dec_pc,
  output logic                  o_dec_guesses_branch,
  output logic [ADDR_WIDTH-1:0] o_dec_prediction,
  input  logic                  i_dec_ready,
  input  logic                  i_dec_redirect,
  input  logic [ADDR_WIDTH-1:0] i_dec_new_pc,
  input  logic                  i_be_flush,
  input  logic [ADDR_WIDTH-1:0] i_be_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_credit_used;
  fq_entry_t        w_head;
  fq_entry_t        w_push_data;
  logic             w_accept, w_deq, w_dropping, w_dec_redir, w_pred_taken;
  logic             w_push, w_clear, w_redirect;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a returning
  // response always finds a free slot.
  assign w_credit_used = {1'b0, w_count} + {1'b0, outstanding_q};
  assign o_fetch_req   = rst_n && (w_credit_used < (CNT_W+1)'(DEPTH)) && !i_be_flush;
  assign o_dec_valid   = (w_count != '0) && !i_be_flush;
  assign o_fetch_pc    = fetch_pc_q;

  assign w_accept     = o_fetch_req && i_fetch_ack;
  assign w_deq        = o_dec_valid && i_dec_ready;
  assign w_dropping   = i_rsp_valid && (drop_cnt_q != '0);
  assign w_dec_redir  = w_deq && i_dec_redirect && !i_be_flush;
  assign w_pred_taken = i_rsp_valid && !w_dropping && i_rsp_guesses_branch
                        && !i_be_flush && !w_dec_redir;
  assign w_redirect   = i_be_flush || w_dec_redir || w_pred_taken;
  assign w_push       = i_rsp_valid && !w_dropping && !i_be_flush && !w_dec_redir;
  assign w_clear      = i_be_flush || w_dec_redir;

  assign w_push_data = '{instr:          i_rsp_instr,
                         pc:             i_rsp_pc,
                         guesses_branch: i_rsp_guesses_branch,
                         prediction:     i_rsp_prediction};

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(w_accept) - CNT_W'(i_rsp_valid);

    drop_cnt_d = drop_cnt_q;
    if (w_redirect) begin
      drop_cnt_d = outstanding_d;
    end else if (w_dropping) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (i_be_flush) begin
      fetch_pc_d = i_be_pc;
    end else if (w_dec_redir) begin
      fetch_pc_d = i_dec_new_pc;
    end else if (w_pred_taken) begin
      fetch_pc_d = i_rsp_prediction;
    end else if (w_accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  fq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_deq),
    .i_clear     (w_clear),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign o_dec_instr          = w_head.instr;
  assign o_dec_pc             = w_head.pc;
  assign o_dec_guesses_branch = w_head.guesses_branch;
  assign o_dec_prediction     = w_head.prediction;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_queue
// Brief   : Self-checking bench for fetch_queue with a queue-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          o_fetch_req;
  logic [AW-1:0] o_fetch_pc;
  logic          i_fetch_ack = 1'b0;
  logic          i_rsp_valid = 1'b0;
  logic [31:0]   i_rsp_instr = '0;
  logic [AW-1:0] i_rsp_pc = '0;
  logic          i_rsp_guesses_branch = 1'b0;
  logic [AW-1:0] i_rsp_prediction = '0;
  logic          o_dec_valid;
  logic [31:0]   o_dec_instr;
  logic [AW-1:0] o_dec_pc;
  logic          o_dec_guesses_branch;
  logic [AW-1:0] o_dec_prediction;
  logic          i_dec_ready = 1'b0;
  logic          i_dec_redirect = 1'b0;
  logic [AW-1:0] i_dec_new_pc = '0;
  logic          i_be_flush = 1'b0;
  logic [AW-1:0] i_be_pc = '0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_fetch_req(o_fetch_req), .o_fetch_pc(o_fetch_pc), .i_fetch_ack(i_fetch_ack),
    .i_rsp_valid(i_rsp_valid), .i_rsp_instr(i_rsp_instr), .i_rsp_pc(i_rsp_pc),
    .i_rsp_guesses_branch(i_rsp_guesses_branch), .i_rsp_prediction(i_rsp_prediction),
    .o_dec_valid(o_dec_valid), .o_dec_instr(o_dec_instr), .o_dec_pc(o_dec_pc),
    .o_dec_guesses_branch(o_dec_guesses_branch), .o_dec_prediction(o_dec_prediction),
    .i_dec_ready(i_dec_ready), .i_dec_redirect(i_dec_redirect), .i_dec_new_pc(i_dec_new_pc),
    .i_be_flush(i_be_flush), .i_be_pc(i_be_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          gb;
    logic [AW-1:0] pred;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] pend[$];
  int            outst;
  int            drop;
  logic [AW-1:0] mpc;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            rand_gb = 1'b0;
  logic [AW-1:0] gb_pc = 32'hFFFF_FFFF;
  logic [AW-1:0] gb_pred = '0;

  function automatic bit exp_req();
    return ((mq.size() + outst) < DEPTH) && !i_be_flush;
  endfunction

  function automatic bit exp_dv();
    return (mq.size() != 0) && !i_be_flush;
  endfunction

  // Apply one cycle of inputs, then wait to the falling edge for sampling.
  task automatic drive(input bit ack, input bit rsp, input bit rdy, input bit redir,
                       input logic [AW-1:0] npc, input bit fl, input logic [AW-1:0] bpc);
    i_be_flush     = fl;
    i_be_pc        = bpc;
    i_dec_ready    = rdy;
    i_dec_redirect = redir;
    i_dec_new_pc   = npc;
    i_fetch_ack    = ack && exp_req();
    if (rsp && pend.size() > 0) begin
      i_rsp_valid = 1'b1;
      i_rsp_pc    = pend[0];
      i_rsp_instr = pend[0] ^ 32'hA5A5_0000;
      if (rand_gb) begin
        i_rsp_guesses_branch = ($urandom_range(0, 5) == 0);
        i_rsp_prediction     = $urandom & 32'h0000_FFFC;
      end else begin
        i_rsp_guesses_branch = (pend[0] == gb_pc);
        i_rsp_prediction     = gb_pred;
      end
    end else begin
      i_rsp_valid          = 1'b0;
      i_rsp_pc             = '0;
      i_rsp_instr          = '0;
      i_rsp_guesses_branch = 1'b0;
      i_rsp_prediction     = '0;
    end
    @(negedge clk);
  endtask

  // Reference model: advance one clock using the rules for requests, responses and redirects.
  task automatic step();
    bit acc, deq, rsp, taken;
    int onext;
    acc   = exp_req() && i_fetch_ack;
    deq   = exp_dv() && i_dec_ready;
    rsp   = i_rsp_valid;
    taken = 1'b0;
    if (rsp) void'(pend.pop_front());
    if (acc) pend.push_back(mpc);
    onext = outst + int'(acc) - int'(rsp);
    if (i_be_flush) begin
      mq.delete(); mpc = i_be_pc; drop = onext;
    end else if (deq && i_dec_redirect) begin
      mq.delete(); mpc = i_dec_new_pc; drop = onext;
    end else begin
      if (deq) void'(mq.pop_front());
      if (rsp) begin
        if (drop > 0) drop--;
        else begin
          mq.push_back('{i_rsp_instr, i_rsp_pc, i_rsp_guesses_branch, i_rsp_prediction});
          taken = i_rsp_guesses_branch;
        end
      end
      if (taken) begin mpc = i_rsp_prediction; drop = onext; end
      else if (acc) mpc = mpc + 4;
    end
    outst = onext;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_fetch_ack = 0; i_rsp_valid = 0; i_dec_ready = 0; i_dec_redirect = 0; i_be_flush = 0;
    mq.delete(); pend.delete(); outst = 0; drop = 0; mpc = '0;
    gb_pc = 32'hFFFF_FFFF; rand_gb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_fetch_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", o_fetch_req); end
    n_cmp++; if (o_dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", o_dec_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_fetch_req !== 1'b1) begin n_err++; $display("FAIL post_reset_req: got %b want 1", o_fetch_req); end
    n_cmp++; if (o_fetch_pc !== 32'h0) begin n_err++; $display("FAIL post_reset_pc: got %h want 0", o_fetch_pc); end
    step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0); step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_fetch_pc !== 32'h0 || o_fetch_req !== 1'b0 || o_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got pc=%h req=%b dv=%b want 0/0/0", o_fetch_pc, o_fetch_req, o_dec_valid);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1, 1, 1, 0, 0, 0, 0);
      n_cmp++; if (o_fetch_pc !== 32'(4*k)) begin n_err++; $display("FAIL stream_fpc: got %h want %h", o_fetch_pc, 32'(4*k)); end
      if (k >= 2) begin
        n_cmp++;
        if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'(4*(k-2)) || o_dec_instr !== (32'(4*(k-2)) ^ 32'hA5A5_0000)) begin
          n_err++; $display("FAIL stream_dec: got v=%b pc=%h instr=%h want pc=%h", o_dec_valid, o_dec_pc, o_dec_instr, 32'(4*(k-2)));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 12; k++) begin drive(1, 1, 0, 0, 0, 0, 0); step(); end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      if (i == 0) begin
        n_cmp++; if (o_fetch_req !== 1'b0) begin n_err++; $display("FAIL bp_full_req: got %b want 0", o_fetch_req); end
      end
      n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'(4*i)) begin
        n_err++; $display("FAIL bp_drain: got v=%b pc=%h want pc=%h", o_dec_valid, o_dec_pc, 32'(4*i));
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_fetch_req !== 1'b1 || o_fetch_pc !== 32'h20 || o_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_resume: got req=%b pc=%h dv=%b want 1/20/0", o_fetch_req, o_fetch_pc, o_dec_valid);
    end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h10); step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (o_fetch_pc !== 32'(32'h10 + 4*k)) begin n_err++; $display("FAIL flush_setup_pc: got %h want %h", o_fetch_pc, 32'(32'h10 + 4*k)); end
      step();
    end
    drive(1, 0, 1, 0, 0, 1, 32'h100);
    n_cmp++; if (o_fetch_req !== 1'b0 || o_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_gate: got req=%b dv=%b want 0/0", o_fetch_req, o_dec_valid);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      n_cmp++; if (o_fetch_pc !== 32'h100 || o_dec_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_drop: got pc=%h dv=%b want 100/0", o_fetch_pc, o_dec_valid);
      end
      step();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_last: got dv=%b want 0", o_dec_valid); end
    step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h100) begin
      n_err++; $display("FAIL flush_restart: got v=%b pc=%h want 1/100", o_dec_valid, o_dec_pc);
    end
    step();
  endtask

  task automatic test_dec_redirect();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h20); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    repeat (3) begin drive(1, 1, 0, 0, 0, 0, 0); step(); end
    drive(0, 0, 1, 1, 32'h80, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h20) begin
      n_err++; $display("FAIL redir_head: got v=%b pc=%h want 1/20", o_dec_valid, o_dec_pc);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b0 || o_fetch_pc !== 32'h80) begin
      n_err++; $display("FAIL redir_clear: got dv=%b pc=%h want 0/80", o_dec_valid, o_fetch_pc);
    end
    step();
    drive(1, 1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h80) begin
      n_err++; $display("FAIL redir_restart: got v=%b pc=%h want 1/80", o_dec_valid, o_dec_pc);
    end
    step();
  endtask

  task automatic test_pred_taken();
    do_reset();
    gb_pc = 32'h40; gb_pred = 32'h200;
    drive(0, 0, 0, 0, 0, 1, 32'h40); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_fetch_pc !== 32'h200) begin n_err++; $display("FAIL pt_fpc: got %h want 200", o_fetch_pc); end
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h40 || o_dec_guesses_branch !== 1'b1 || o_dec_prediction !== 32'h200) begin
      n_err++; $display("FAIL pt_entry: got v=%b pc=%h gb=%b pred=%h want 1/40/1/200", o_dec_valid, o_dec_pc, o_dec_guesses_branch, o_dec_prediction);
    end
    step();
    repeat (2) begin drive(0, 1, 0, 0, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (o_dec_pc !== 32'h40) begin n_err++; $display("FAIL pt_keep: got %h want 40", o_dec_pc); end
    step();
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h200) begin
      n_err++; $display("FAIL pt_target: got v=%b pc=%h want 1/200", o_dec_valid, o_dec_pc);
    end
    step();
    gb_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_simultaneous();
    do_reset();
    gb_pc = 32'h64; gb_pred = 32'h500;
    drive(0, 0, 0, 0, 0, 1, 32'h60); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0); step();
    drive(1, 1, 1, 1, 32'h80, 1, 32'h300);
    n_cmp++; if (o_fetch_req !== 1'b0 || o_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL sim_gate: got req=%b dv=%b want 0/0", o_fetch_req, o_dec_valid);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_fetch_pc !== 32'h300 || o_dec_valid !== 1'b0) begin
      n_err++; $display("FAIL sim_prio: got pc=%h dv=%b want 300/0", o_fetch_pc, o_dec_valid);
    end
    step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_dec_valid !== 1'b1 || o_dec_pc !== 32'h300) begin
      n_err++; $display("FAIL sim_restart: got v=%b pc=%h want 1/300", o_dec_valid, o_dec_pc);
    end
    step();
    gb_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    rand_gb = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3,
            $urandom_range(0, 15) == 0, $urandom & 32'h0000_FFFC,
            $urandom_range(0, 31) == 0, $urandom & 32'h0000_FFFC);
      n_cmp++; if (o_fetch_req !== exp_req() || o_fetch_pc !== mpc) begin
        n_err++; if (n_err < 20) $display("FAIL rnd_fetch: got req=%b pc=%h want %b/%h", o_fetch_req, o_fetch_pc, exp_req(), mpc);
      end
      n_cmp++; if (o_dec_valid !== exp_dv()) begin
        n_err++; if (n_err < 20) $display("FAIL rnd_dv: got %b want %b", o_dec_valid, exp_dv());
      end
      if (mq.size() != 0) begin
        h = mq[0];
        n_cmp++; if (o_dec_pc !== h.pc || o_dec_instr !== h.instr || o_dec_guesses_branch !== h.gb || o_dec_prediction !== h.pred) begin
          n_err++; if (n_err < 20) $display("FAIL rnd_head: got pc=%h instr=%h gb=%b pred=%h want %h/%h/%b/%h",
            o_dec_pc, o_dec_instr, o_dec_guesses_branch, o_dec_prediction, h.pc, h.instr, h.gb, h.pred);
        end
      end
      step();
    end
    rand_gb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_dec_redirect();
    test_pred_taken();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
